clk_mgr: RTL
============

CLK_MGR -- requirements
Module: clk_mgr

Interface
REQ-001 SHALL provide parameter NUM_CH, default 4, meaning the number of downstream reset channels (1..16).
REQ-002 SHALL provide parameter RST_CYCLES, default 4, meaning the PLL reset pulse length in cycles.
REQ-003 SHALL provide parameter LOCK_TIMEOUT, default 1024, meaning the maximum number of cycles to wait for lock per attempt.
REQ-004 SHALL provide parameter STABLE_CYCLES, default 64, meaning the number of consecutive locked cycles required before release.
REQ-005 SHALL provide parameter STAGGER, default 8, meaning the number of cycles between successive channel releases.
REQ-006 SHALL provide parameter MAX_RETRY, default 3, meaning the number of failed lock attempts before FAIL (macro-dependent).
REQ-007 SHALL provide port clk24_ref  input  1  free-running reference clock, independent of the PLL.
REQ-008 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-009 SHALL provide port pll_locked  input  1  PLL lock flag, asynchronous to clk24_ref.
REQ-010 SHALL provide port pll_rst  output  1  active-high PLL reset.
REQ-011 SHALL provide port ch_rst_n  output  NUM_CH  per-domain active-low resets.
REQ-012 SHALL provide port ready  output  1  high when all channels are released and lock is held.
REQ-013 SHALL provide port fail  output  1  lock failure latched.
REQ-014 SHALL provide port relock_cnt  output  8  saturating count of lock losses.
REQ-015 SHALL provide port state  output  3  current FSM state, for debug.

Function
REQ-016 SHALL synchronise pll_locked through a 2-flop synchroniser to lock_s; all decisions SHALL use lock_s only.
REQ-017 SHALL implement FSM states with the following encodings: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, FAIL=5.
REQ-018 SHALL register all outputs.
REQ-019 SHALL hold pll_rst=1 in PLL_RST and FAIL, and pll_rst=0 in all other states.
REQ-020 In PLL_RST, SHALL remain for exactly RST_CYCLES cycles, then enter WAIT_LOCK with the timeout counter cleared.
REQ-021 In WAIT_LOCK, SHALL enter STABLE when lock_s=1; when the counter reaches LOCK_TIMEOUT-1 with no lock, SHALL increment the attempt counter and enter PLL_RST.
REQ-022 In STABLE, SHALL enter RELEASE after STABLE_CYCLES consecutive lock_s=1 cycles; if lock_s=0, SHALL return to WAIT_LOCK with the timeout counter cleared, and the attempt counter SHALL be unchanged.
REQ-023 In RELEASE, SHALL deassert ch_rst_n[i] at cycle i*STAGGER after entry (ch 0 on the first RELEASE cycle); one cycle after ch_rst_n[NUM_CH-1] deasserts, SHALL enter RUN and set ready=1.
REQ-024 On entering RUN, SHALL clear the attempt counter.
REQ-025 When lock_s=0 in RELEASE or RUN, SHALL, on the next edge, drive all ch_rst_n to 0, set ready=0, increment relock_cnt (saturating at 255, no wrap), and enter PLL_RST.
REQ-026 Channel resets SHALL be released strictly in ascending index order and asserted simultaneously.
REQ-027 When NUM_CH=1, RELEASE SHALL last one cycle.
REQ-028 Counters SHALL be sized to clog2 of the largest parameter.

Reset
REQ-029 While rst_n=0 (asynchronous assert), SHALL hold state=PLL_RST, pll_rst=1, ch_rst_n=0, ready=0, fail=0, relock_cnt=0, all counters and synchroniser flops 0.
REQ-030 Deassertion of rst_n SHALL take effect on the next clk24_ref edge and begin a fresh RST_CYCLES PLL reset.
REQ-031 Reset mid-RELEASE or mid-RUN SHALL immediately re-assert all ch_rst_n.

Configuration
REQ-032 With macro CLK_MGR_FAIL_LATCH_EN defined, a WAIT_LOCK timeout while attempt count equals MAX_RETRY-1 SHALL enter FAIL: pll_rst=1, fail=1, ch_rst_n=0, exited only by rst_n.
REQ-033 Without CLK_MGR_FAIL_LATCH_EN, retries SHALL be unlimited, fail SHALL be tied to 0, and FAIL SHALL be unreachable.

Verification
REQ-034 Defaults; pll_locked rises 20 cycles after rst_n release -> pll_rst high for exactly 4 cycles, ch_rst_n[0] deasserts 64+ cycles after lock_s, ch_rst_n[3] exactly 24 cycles after ch_rst_n[0], ready 1 cycle later.
REQ-035 In RUN, pll_locked low for one cycle -> all ch_rst_n=0 and ready=0 within 3 cycles of the drop, relock_cnt=1, pll_rst pulses 4 cycles, full release sequence repeats.
REQ-036 In STABLE, lock drops at cycle 30 and returns -> no pll_rst pulse, stable count restarts, and release occurs only after 64 further locked cycles.
REQ-037 pll_locked held 0 with macro defined -> 3 timeouts of 1024 cycles each, then fail=1, pll_rst=1 permanently; without the macro -> pll_rst pulses every 1028 cycles and fail stays 0.
REQ-038 300 forced lock losses in RUN -> relock_cnt saturates at 255.
REQ-039 rst_n asserted mid-RELEASE after ch 1 is released -> all outputs at reset values asynchronously, before the next edge.

Source files
------------

// File: rtl/clk_mgr.sv
// rtl/clk_mgr.sv - PLL lock supervisor with staggered per-domain reset release
//
// Ports:
//   clk24_ref  in   1       free-running reference clock, independent of the PLL
//   rst_n      in   1       asynchronous active-low reset
//   pll_locked in   1       PLL lock flag, asynchronous to clk24_ref
//   pll_rst    out  1       active-high PLL reset
//   ch_rst_n   out  NUM_CH  per-domain active-low resets, released in ascending order
//   ready      out  1       all channels released and lock held
//   fail       out  1       lock failure latched
//   relock_cnt out  8       saturating count of lock losses after release began
//   state      out  3       current FSM state (debug)
//
// Optional feature macro: CLK_MGR_FAIL_LATCH_EN. When defined, the block gives
// up after MAX_RETRY consecutive lock timeouts and parks in FAIL (PLL held in
// reset) until rst_n. When undefined, lock attempts repeat forever and fail=0.
module clk_mgr #(
    parameter int NUM_CH        = 4,
    parameter int RST_CYCLES    = 4,
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int STABLE_CYCLES = 64,
    parameter int STAGGER       = 8,
    parameter int MAX_RETRY     = 3
) (
    input  logic              clk24_ref,
    input  logic              rst_n,
    input  logic              pll_locked,
    output logic              pll_rst,
    output logic [NUM_CH-1:0] ch_rst_n,
    output logic              ready,
    output logic              fail,
    output logic [7:0]        relock_cnt,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAIL      = 3'd5
    } state_t;

    // One shared cycle counter serves every timed state, so it must hold the
    // longest interval: PLL reset, lock timeout, stable window or the release
    // span (last channel is released at cycle (NUM_CH-1)*STAGGER).
    localparam int REL_LAST = (NUM_CH - 1) * STAGGER;
    localparam int MAX_A    = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B    = (STABLE_CYCLES > REL_LAST + 1) ? STABLE_CYCLES : REL_LAST + 1;
    localparam int MAX_P    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW       = (MAX_P > 1) ? $clog2(MAX_P) : 1;
    localparam int AW       = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CW-1:0] RST_LAST_C    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST_C   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST_C = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] REL_LAST_C    = CW'(REL_LAST);
`ifdef CLK_MGR_FAIL_LATCH_EN
    localparam logic [AW-1:0] RETRY_LAST_C  = AW'(MAX_RETRY - 1);
`endif

    logic [1:0]        sync_q;
    logic              lock_s;
    state_t            state_q, state_nxt;
    logic [CW-1:0]     cnt_q, cnt_nxt;
    logic [AW-1:0]     attempt_q, attempt_nxt;
    logic [7:0]        relock_q, relock_nxt;
    logic              pll_rst_q, pll_rst_nxt;
    logic [NUM_CH-1:0] ch_q, ch_nxt;
    logic              ready_q, ready_nxt;

    // pll_locked comes from the PLL's own domain; only lock_s is ever decoded.
    assign lock_s = sync_q[1];

    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        attempt_nxt = attempt_q;
        relock_nxt  = relock_q;

        unique case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST_C) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end

            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else if (cnt_q == LOCK_LAST_C) begin
                    cnt_nxt = '0;
`ifdef CLK_MGR_FAIL_LATCH_EN
                    if (attempt_q == RETRY_LAST_C) begin
                        state_nxt = FAIL;
                    end else begin
                        state_nxt   = PLL_RST;
                        attempt_nxt = attempt_q + 1'b1;
                    end
`else
                    // Unlimited retries: the attempt count only saturates.
                    state_nxt = PLL_RST;
                    if (attempt_q != '1) begin
                        attempt_nxt = attempt_q + 1'b1;
                    end
`endif
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end

            STABLE: begin
                // A glitch here is not a failed attempt: go back to waiting
                // without pulsing the PLL and restart the stable window.
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt_q == STABLE_LAST_C) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end

            RELEASE: begin
                if (!lock_s) begin
                    state_nxt = PLL_RST;
                    cnt_nxt   = '0;
                    if (relock_q != 8'hFF) begin
                        relock_nxt = relock_q + 1'b1;
                    end
                end else if (cnt_q == REL_LAST_C) begin
                    state_nxt   = RUN;
                    cnt_nxt     = '0;
                    attempt_nxt = '0;
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end

            RUN: begin
                if (!lock_s) begin
                    state_nxt = PLL_RST;
                    cnt_nxt   = '0;
                    if (relock_q != 8'hFF) begin
                        relock_nxt = relock_q + 1'b1;
                    end
                end
            end

            FAIL: begin
                state_nxt = FAIL;
            end

            default: begin
                state_nxt = PLL_RST;
                cnt_nxt   = '0;
            end
        endcase

        // Outputs are decoded from the next state so that, once registered,
        // they line up with the state register on the same edge.
        pll_rst_nxt = (state_nxt == PLL_RST) || (state_nxt == FAIL);
        ready_nxt   = (state_nxt == RUN);
        for (int i = 0; i < NUM_CH; i++) begin
            // Channel i opens at RELEASE cycle i*STAGGER; cnt_nxt is the
            // cycle index the registered value will be visible in.
            ch_nxt[i] = (state_nxt == RUN) ||
                        ((state_nxt == RELEASE) && (cnt_nxt >= CW'(i * STAGGER)));
        end
    end

    always_ff @(posedge clk24_ref or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            attempt_q <= '0;
            relock_q  <= '0;
            pll_rst_q <= 1'b1;
            ch_q      <= '0;
            ready_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], pll_locked};
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            attempt_q <= attempt_nxt;
            relock_q  <= relock_nxt;
            pll_rst_q <= pll_rst_nxt;
            ch_q      <= ch_nxt;
            ready_q   <= ready_nxt;
        end
    end

`ifdef CLK_MGR_FAIL_LATCH_EN
    logic fail_q;

    always_ff @(posedge clk24_ref or negedge rst_n) begin
        if (!rst_n) begin
            fail_q <= 1'b0;
        end else begin
            fail_q <= (state_nxt == FAIL);
        end
    end

    assign fail = fail_q;
`else
    assign fail = 1'b0;
`endif

    assign pll_rst    = pll_rst_q;
    assign ch_rst_n   = ch_q;
    assign ready      = ready_q;
    assign relock_cnt = relock_q;
    assign state      = state_q;

endmodule
